// File: rtl/shift_reg_univ_pkg.sv
// Shared definitions for the universal shift register: mode and FSM state encodings,
// plus a helper that tells which modes move bits through sout.
package seq_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_SET   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) ||
               (m == MODE_ROTL) || (m == MODE_ROTR);
    endfunction

endpackage

// File: rtl/shift_reg_univ_step.sv
// One-step next-state logic for the universal register; shared by the single-cycle
// IDLE path and the multi-cycle shift engine.
module shift_reg_step
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out
);

    always_comb begin
        q_next  = q;
        bit_out = 1'b0;
        case (mode)
            MODE_HOLD:  q_next = q;
            MODE_LOAD:  q_next = d;
            MODE_SHL: begin
                q_next  = {q[WIDTH-2:0], sin};
                bit_out = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next  = {sin, q[WIDTH-1:1]};
                bit_out = q[0];
            end
            MODE_ROTL: begin
                q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
                bit_out = q[WIDTH-1];
            end
            MODE_ROTR: begin
                q_next  = {q[0], q[WIDTH-1:1]};
                bit_out = q[0];
            end
            MODE_CLEAR: q_next = '0;
            MODE_SET:   q_next = '1;
            default:    q_next = q;
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register with a start/busy/done multi-cycle shift engine.
// Optional parity output enabled by defining SHIFT_REG_PARITY_EN.
//
//   state    | meaning
//   ST_IDLE  | mode applied each clock; shift-mode start launches the engine
//   ST_SHIFT | one latched step per clock, live inputs ignored, busy=1
//   ST_DONE  | done=1 for this one cycle; otherwise behaves exactly as ST_IDLE
module shift_reg_univ
    import seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sout,
    output logic             busy,
`ifdef SHIFT_REG_PARITY_EN
    output logic             par,
`endif
    output logic             done
);

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       lat_mode;
    logic             lat_sin;

    logic [2:0]       step_mode;
    logic             step_sin;
    logic [WIDTH-1:0] q_next;
    logic             bit_out;
    logic             take_start;
    logic             q_upd;
    logic             sout_upd;
    logic [WIDTH-1:0] q_d;
    logic [AMT_W-1:0] amt_clamped;

    always_comb begin
        step_mode   = (state == ST_SHIFT) ? lat_mode : mode;
        step_sin    = (state == ST_SHIFT) ? lat_sin  : sin;
        take_start  = (state != ST_SHIFT) && start && is_shift_mode(mode);
        // The launch cycle only latches; the first step happens on the next edge.
        q_upd       = (state == ST_SHIFT) || !take_start;
        sout_upd    = q_upd && is_shift_mode(step_mode);
        q_d         = q_upd ? q_next : q;
        amt_clamped = (amt > AMT_MAX) ? AMT_MAX : amt;
    end

    shift_reg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (q),
        .mode    (step_mode),
        .d       (d),
        .sin     (step_sin),
        .q_next  (q_next),
        .bit_out (bit_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lat_mode <= MODE_HOLD;
            lat_sin  <= 1'b0;
            q        <= '0;
            qn       <= '1;
            sout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SHIFT_REG_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            q  <= q_d;
            qn <= ~q_d;
            if (sout_upd) begin
                sout <= bit_out;
            end
`ifdef SHIFT_REG_PARITY_EN
            par <= ^q_d;
`endif
            case (state)
                ST_SHIFT: begin
                    cnt <= cnt - AMT_ONE;
                    if (cnt == AMT_ONE) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (take_start) begin
                        lat_mode <= mode;
                        lat_sin  <= sin;
                        if (amt_clamped == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            cnt   <= amt_clamped;
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8) with a queue scoreboard of expected outputs.
module tb_shift_reg_univ;

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_LOAD  = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_SHR   = 3'b011;
    localparam logic [2:0] M_ROTL  = 3'b100;
    localparam logic [2:0] M_ROTR  = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;
    localparam logic [2:0] M_SET   = 3'b111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode = M_HOLD;
    logic       start = 1'b0;
    logic [3:0] amt = 4'd0;
    logic [7:0] d = 8'h00;
    logic       sin = 1'b0;
    logic [7:0] q, qn;
    logic       sout, busy, done;
`ifdef SHIFT_REG_PARITY_EN
    logic       par;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       sout;
        logic       busy;
        logic       done;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    shift_reg_univ dut (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .start (start),
        .amt   (amt),
        .d     (d),
        .sin   (sin),
        .q     (q),
        .qn    (qn),
        .sout  (sout),
        .busy  (busy),
`ifdef SHIFT_REG_PARITY_EN
        .par   (par),
`endif
        .done  (done)
    );

    task automatic push(input string tag, input logic [7:0] eq, input logic es,
                        input logic eb, input logic ed);
        exp_t e;
        e.tag = tag; e.q = eq; e.sout = es; e.busy = eb; e.done = ed;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        logic [18:0] got, want;
        e = sb.pop_front();
        got  = {q, qn, sout, busy, done};
        want = {e.q, ~e.q, e.sout, e.busy, e.done};
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: q/qn/sout/busy/done got %h/%h/%b/%b/%b expected %h/%h/%b/%b/%b",
                   e.tag, q, qn, sout, busy, done, e.q, ~e.q, e.sout, e.busy, e.done);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, record the expectation, check after the edge.
    task automatic cyc(input string tag, input logic [2:0] m, input logic st, input logic [3:0] a,
                       input logic [7:0] dd, input logic s,
                       input logic [7:0] eq, input logic es, input logic eb, input logic ed);
        @(negedge clk);
        mode = m; start = st; amt = a; d = dd; sin = s;
        push(tag, eq, es, eb, ed);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        logic [7:0] exp_q;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        push("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check_pop();
        @(negedge clk);
        rst = 1'b0;

        // Load / hold / set / clear
        cyc("load_a5", M_LOAD, 0, 0, 8'hA5, 0, 8'hA5, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("hold_a5", M_HOLD, 0, 0, 8'h3C, 1, 8'hA5, 0, 0, 0);
        cyc("set", M_SET, 0, 0, 8'h00, 0, 8'hFF, 0, 0, 0);
        cyc("clear", M_CLEAR, 0, 0, 8'hFF, 1, 8'h00, 0, 0, 0);

        // Single-cycle shifts and rotate
        cyc("load_81", M_LOAD, 0, 0, 8'h81, 0, 8'h81, 0, 0, 0);
        cyc("shl_sin1", M_SHL, 0, 0, 8'h00, 1, 8'h03, 1, 0, 0);
        cyc("shr_sin0", M_SHR, 0, 0, 8'h00, 0, 8'h01, 1, 0, 0);
        cyc("rotr", M_ROTR, 0, 0, 8'h00, 0, 8'h80, 1, 0, 0);

        // Multi-cycle ROTL by 3 with live inputs toggled while busy
        cyc("load_b4", M_LOAD, 0, 0, 8'hB4, 0, 8'hB4, 1, 0, 0);
        cyc("rotl3_start", M_ROTL, 1, 4'd3, 8'h00, 0, 8'hB4, 1, 1, 0);
        cyc("rotl3_step1", M_LOAD, 1, 4'd0, 8'h00, 1, 8'h69, 1, 1, 0);
        cyc("rotl3_step2", M_SET, 0, 4'd7, 8'hFF, 0, 8'hD2, 0, 1, 0);
        cyc("rotl3_step3", M_CLEAR, 1, 4'd2, 8'h11, 1, 8'hA5, 1, 0, 1);
        cyc("rotl3_after", M_HOLD, 0, 0, 8'h00, 0, 8'hA5, 1, 0, 0);

        // Zero-length start goes straight to done
        cyc("shr0_start", M_SHR, 1, 4'd0, 8'h00, 0, 8'hA5, 1, 0, 1);
        cyc("shr0_after", M_HOLD, 0, 0, 8'h00, 0, 8'hA5, 1, 0, 0);

        // Start with a non-shift mode is a plain load
        cyc("start_load", M_LOAD, 1, 4'd2, 8'h3C, 0, 8'h3C, 1, 0, 0);
        cyc("start_load_after", M_HOLD, 0, 0, 8'h00, 0, 8'h3C, 1, 0, 0);

        // amt=12 clamps to 8: full-width SHL with latched sin=0
        cyc("set_ff", M_SET, 0, 0, 8'h00, 0, 8'hFF, 1, 0, 0);
        cyc("shl12_start", M_SHL, 1, 4'd12, 8'h00, 0, 8'hFF, 1, 1, 0);
        exp_q = 8'hFF;
        for (int i = 1; i <= 8; i++) begin
            exp_q = {exp_q[6:0], 1'b0};
            cyc("shl12_step", M_HOLD, 0, 0, 8'h00, 1, exp_q, 1, (i < 8), (i == 8));
        end
        cyc("shl12_after", M_HOLD, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0);

        // Async reset after 2 of 5 steps
        cyc("load_0f", M_LOAD, 0, 0, 8'h0F, 0, 8'h0F, 1, 0, 0);
        cyc("shl5_start", M_SHL, 1, 4'd5, 8'h00, 1, 8'h0F, 1, 1, 0);
        cyc("shl5_step1", M_HOLD, 0, 0, 8'h00, 0, 8'h1F, 0, 1, 0);
        cyc("shl5_step2", M_HOLD, 0, 0, 8'h00, 0, 8'h3F, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        push("midshift_reset", 8'h00, 0, 0, 0);
        #1;
        check_pop();
        @(negedge clk);
        rst = 1'b0;
        cyc("post_reset_load", M_LOAD, 0, 0, 8'h5A, 0, 8'h5A, 0, 0, 0);
        cyc("post_reset_hold", M_HOLD, 0, 0, 8'h00, 0, 8'h5A, 0, 0, 0);

`ifdef SHIFT_REG_PARITY_EN
        cyc("load_07", M_LOAD, 0, 0, 8'h07, 0, 8'h07, 0, 0, 0);
        n_tests++;
        assert (par === 1'b1) else begin
            n_fail++;
            $error("FAIL par_07: got %b expected 1", par);
        end
        cyc("load_03", M_LOAD, 0, 0, 8'h03, 0, 8'h03, 0, 0, 0);
        n_tests++;
        assert (par === 1'b0) else begin
            n_fail++;
            $error("FAIL par_03: got %b expected 0", par);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
